// File: rtl/line_fetch_pkg.sv
// Shared types and address-field geometry for the single-line instruction fetch buffer.
package line_fetch_pkg;

  localparam int LINE_BYTES = 64;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int ADDR_W     = 15;
  localparam int TAG_W      = 9;
  localparam int WORD_W     = 4;
  localparam int INSN_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/line_fetch_if.sv
// Core fetch handshake plus instruction-ROM line bus; slave is the fetch unit, master drives it.
interface line_fetch_if;
  import line_fetch_pkg::*;

  logic                  fetch_valid;
  logic [ADDR_W-1:0]     fetch_addr;
  logic                  flush;
  logic                  fetch_done;
  logic [INSN_W-1:0]     fetch_insn;
  logic                  fetch_err;
  logic                  mem_cs;
  logic                  mem_addr_valid;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_data_ready;
  logic [LINE_W-1:0]     mem_data;

  modport slave (
    input  fetch_valid, fetch_addr, flush, mem_data_ready, mem_data,
    output fetch_done, fetch_insn, fetch_err, mem_cs, mem_addr_valid, mem_addr
  );

  modport master (
    output fetch_valid, fetch_addr, flush, mem_data_ready, mem_data,
    input  fetch_done, fetch_insn, fetch_err, mem_cs, mem_addr_valid, mem_addr
  );

endinterface

// File: rtl/line_fetch_word_sel.sv
// Picks one little-endian 32-bit word out of a 64-byte line.
module line_word_sel
  import line_fetch_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [WORD_W-1:0] word_idx,
  output logic [INSN_W-1:0] word
);

  always_comb begin
    word = line[word_idx*INSN_W +: INSN_W];
  end

endmodule

// File: rtl/line_fetch.sv
// Single-line instruction fetch buffer: hit returns from the line, miss fills a whole line from ROM.
module line_fetch
  import line_fetch_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  line_fetch_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                line_valid_q, line_valid_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                flushed_q, flushed_d;

  logic [TAG_W-1:0]    req_tag;
  logic [WORD_W-1:0]   req_word;
  logic                misaligned;
  logic                hit;
  logic [INSN_W-1:0]   sel_word;

  assign req_tag    = bus.fetch_addr[ADDR_W-1:OFF_W];
  assign req_word   = bus.fetch_addr[OFF_W-1:2];
  assign misaligned = (bus.fetch_addr[1:0] != 2'b00);
  assign hit        = line_valid_q && (tag_q == req_tag) && !bus.flush;

  line_word_sel u_word_sel (
    .line     (line_q),
    .word_idx (req_word),
    .word     (sel_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      line_valid_q <= 1'b0;
      wait_q       <= '0;
      flushed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      line_valid_q <= line_valid_d;
      wait_q       <= wait_d;
      flushed_q    <= flushed_d;
    end
  end

  // Line contents are meaningless until line_valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    tag_d        = tag_q;
    line_valid_d = line_valid_q;
    wait_d       = wait_q;
    flushed_d    = flushed_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.fetch_valid) begin
          if (misaligned) begin
            state_d = ST_ERR;
          end else if (hit) begin
            state_d = ST_RESP;
          end else begin
            state_d   = ST_REQ;
            wait_d    = '0;
            flushed_d = 1'b0;
          end
        end
      end
      ST_REQ: begin
        if (bus.flush) begin
          flushed_d = 1'b1;
        end
        // A flush seen anywhere during the fill still returns the word but drops the line.
        if (bus.mem_data_ready) begin
          line_d       = bus.mem_data;
          tag_d        = req_tag;
          line_valid_d = !(bus.flush || flushed_q);
          state_d      = ST_RESP;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          line_valid_d = 1'b0;
          state_d      = ST_ERR;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.flush) begin
      line_valid_d = 1'b0;
    end
  end

  always_comb begin
    bus.mem_cs         = 1'b0;
    bus.mem_addr_valid = 1'b0;
    bus.mem_addr       = '0;
    bus.fetch_done     = 1'b0;
    bus.fetch_insn     = '0;
    bus.fetch_err      = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        bus.mem_cs         = 1'b1;
        bus.mem_addr_valid = 1'b1;
        bus.mem_addr       = {req_tag, {OFF_W{1'b0}}};
      end
      ST_RESP: begin
        bus.fetch_done = 1'b1;
        bus.fetch_insn = sel_word;
      end
      ST_ERR:  bus.fetch_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_fetch.sv
// Scoreboard bench for line_fetch: ROM model responds with a known line pattern, expected words queued per request.
module tb_line_fetch;
  import line_fetch_pkg::*;

  localparam int TO = 8;

  typedef struct packed {
    logic              err;
    logic [INSN_W-1:0] insn;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  logic             model_valid;
  logic [TAG_W-1:0] model_tag;

  line_fetch_if bus ();

  line_fetch #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSN_W-1:0] rom_word(input logic [TAG_W-1:0] tag, input logic [WORD_W-1:0] w);
    if (tag == '0 && w == 4'd1) return 32'h0000_0013;
    return {4'hC, 3'b000, tag, w, 12'h000};
  endfunction

  function automatic logic [LINE_W-1:0] rom_line(input logic [TAG_W-1:0] tag);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = rom_word(tag, WORD_W'(w));
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One core request; ready_after < 0 means the ROM never answers.
  task automatic applyStimulus(input logic [14:0] addr, input int ready_after, input bit flush_in_req);
    bit   mis, exp_hit, exp_bus, exp_err, got;
    int   req_cycles, ready_cyc;
    exp_t e, o;
    mis     = (addr[1:0] != 2'b00);
    exp_hit = !mis && model_valid && (model_tag == addr[14:6]);
    exp_bus = !mis && !exp_hit;
    exp_err = mis || (exp_bus && ready_after < 0);
    e.err   = exp_err;
    e.insn  = exp_err ? 32'h0 : rom_word(addr[14:6], addr[5:2]);
    exp_q.push_back(e);

    @(negedge clk);
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = addr;
    req_cycles = 0;
    ready_cyc  = -1;
    got        = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      bus.mem_data_ready = 1'b0;
      bus.flush          = 1'b0;
      if (bus.fetch_done || bus.fetch_err) begin
        got = 1'b1;
        bus.fetch_valid = 1'b0;
        checkOutput("done_err_exclusive", 32'(bus.fetch_done & bus.fetch_err), 32'h0);
        checkOutput("mem_cs_at_response", 32'(bus.mem_cs), 32'h0);
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_empty", 32'h1, 32'h0);
        end else begin
          o = exp_q.pop_front();
          checkOutput("fetch_err", 32'(bus.fetch_err), 32'(o.err));
          if (!o.err) checkOutput("fetch_insn", bus.fetch_insn, o.insn);
        end
        if (!exp_bus)
          checkOutput("latency_no_bus", 32'(cyc), 32'd1);
        else if (ready_after >= 0)
          checkOutput("latency_after_ready", 32'(cyc), 32'(ready_cyc + 1));
        else
          checkOutput("timeout_req_cycles", 32'(req_cycles), 32'(TO));
      end else if (bus.mem_cs) begin
        checkOutput("mem_addr_valid", 32'(bus.mem_addr_valid), 32'h1);
        checkOutput("mem_addr", 32'(bus.mem_addr), 32'({addr[14:6], 6'b000000}));
        if (flush_in_req && req_cycles == 1) bus.flush = 1'b1;
        if (req_cycles == ready_after) begin
          bus.mem_data_ready = 1'b1;
          bus.mem_data       = rom_line(addr[14:6]);
          ready_cyc          = cyc;
        end
        req_cycles++;
      end
    end
    if (!got) begin
      checkOutput("response_timeout", 32'h0, 32'h1);
      bus.fetch_valid = 1'b0;
    end
    checkOutput("bus_used", 32'(req_cycles != 0), 32'(exp_bus));

    if (exp_bus) begin
      if (ready_after >= 0 && !flush_in_req) begin
        model_valid = 1'b1;
        model_tag   = addr[14:6];
      end else begin
        model_valid = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_valid = 1'b0;
    model_tag   = '0;
    rst                = 1'b1;
    bus.fetch_valid    = 1'b0;
    bus.fetch_addr     = '0;
    bus.flush          = 1'b0;
    bus.mem_data_ready = 1'b0;
    bus.mem_data       = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_done", 32'(bus.fetch_done), 32'h0);
    checkOutput("reset_err", 32'(bus.fetch_err), 32'h0);
    checkOutput("reset_cs", 32'(bus.mem_cs), 32'h0);
    checkOutput("reset_addr_valid", 32'(bus.mem_addr_valid), 32'h0);
    checkOutput("reset_insn", bus.fetch_insn, 32'h0);
    rst = 1'b0;

    applyStimulus(15'h0004, 3, 1'b0);
    applyStimulus(15'h0008, 0, 1'b0);
    applyStimulus(15'h0006, 0, 1'b0);
    applyStimulus(15'h0040, -1, 1'b0);
    applyStimulus(15'h0004, 0, 1'b0);
    applyStimulus(15'h0004, 0, 1'b0);
    applyStimulus(15'h0084, 3, 1'b1);
    applyStimulus(15'h0084, 2, 1'b0);
    applyStimulus(15'h7FFC, 1, 1'b0);
    applyStimulus(15'h7FF0, 0, 1'b0);

    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    model_valid = 1'b0;
    applyStimulus(15'h7FFC, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [TAG_W-1:0] t;
      logic [3:0]       w;
      case ($urandom_range(0, 3))
        0:       t = 9'h000;
        1:       t = 9'h001;
        2:       t = 9'h002;
        default: t = 9'h1FF;
      endcase
      w = 4'($urandom_range(0, 15));
      applyStimulus({t, w, 2'b00}, int'($urandom_range(0, 4)), 1'b0);
    end

    // Reset in the middle of a fill: request must drop and late data must not surface.
    @(negedge clk);
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 15'h0100;
    for (int k = 0; k < 10 && !bus.mem_cs; k++) @(negedge clk);
    checkOutput("rst_test_reached_req", 32'(bus.mem_cs), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_req_cs", 32'(bus.mem_cs), 32'h0);
    checkOutput("rst_mid_req_done", 32'(bus.fetch_done), 32'h0);
    rst = 1'b0;
    bus.fetch_valid    = 1'b0;
    bus.mem_data_ready = 1'b1;
    bus.mem_data       = rom_line(9'h004);
    repeat (2) begin
      @(negedge clk);
      checkOutput("late_data_done", 32'(bus.fetch_done), 32'h0);
      checkOutput("late_data_cs", 32'(bus.mem_cs), 32'h0);
    end
    bus.mem_data_ready = 1'b0;
    model_valid = 1'b0;
    applyStimulus(15'h7FFC, 2, 1'b0);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_fetch.md
LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the bus-wait cycle limit before an error is reported.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 fetch_valid  input  1  SHALL carry the core fetch request, held high until fetch_done or fetch_err.
REQ-005 fetch_addr  input  15  SHALL carry the byte address of the requested instruction, stable while fetch_valid is high.
REQ-006 flush  input  1  SHALL invalidate the line buffer when high.
REQ-007 fetch_done  output  1  SHALL pulse for one cycle when fetch_insn is valid.
REQ-008 fetch_insn  output  32  SHALL carry the fetched instruction, valid only while fetch_done is high.
REQ-009 fetch_err  output  1  SHALL pulse for one cycle on a misaligned address or a bus timeout.
REQ-010 mem_cs  output  1  SHALL be the chip select to the instruction ROM.
REQ-011 mem_addr_valid  output  1  SHALL mark mem_addr as valid.
REQ-012 mem_addr  output  15  SHALL carry the line address {tag, 6'b0}.
REQ-013 mem_data_ready  input  1  SHALL be the ROM line-ready indication.
REQ-014 mem_data  input  512  SHALL carry the 64-byte line; byte k at bits [8k+7:8k].

Function
REQ-015 The block SHALL hold a single 512-bit line buffer, a 9-bit tag (addr[14:6]) and a line_valid bit.
REQ-016 FSM states SHALL be IDLE, REQ, RESP and ERR.
REQ-017 IDLE: fetch_valid with fetch_addr[1:0] != 0 SHALL go to ERR without bus activity.
REQ-018 IDLE: an aligned fetch_valid with line_valid high and tag == fetch_addr[14:6] (a hit) SHALL go to RESP.
REQ-019 IDLE: an aligned fetch_valid that misses SHALL go to REQ and clear the wait counter.
REQ-020 In REQ, mem_cs and mem_addr_valid SHALL be 1 and mem_addr SHALL be {fetch_addr[14:6], 6'b0}; in all other states they SHALL be 0.
REQ-021 In REQ, a cycle with mem_data_ready sampled high SHALL latch mem_data and the tag, set line_valid, and go to RESP.
REQ-022 In REQ, the wait counter SHALL increment each cycle without mem_data_ready; reaching TIMEOUT-1 SHALL go to ERR with line_valid cleared.
REQ-023 In RESP, fetch_done SHALL be 1 and fetch_insn SHALL be line word fetch_addr[5:2] (bits [32w+31:32w], little-endian); the FSM then returns to IDLE.
REQ-024 In ERR, fetch_err SHALL be 1 for that cycle only; the FSM then returns to IDLE.
REQ-025 Latency: a hit SHALL give fetch_done one cycle after fetch_valid is sampled; a miss SHALL give fetch_done one cycle after mem_data_ready is sampled.
REQ-026 flush SHALL clear line_valid in the same cycle it is sampled, with priority over a concurrent fill; the fill data SHALL still be returned to the core but not retained.
REQ-027 A flush during REQ SHALL NOT abort the bus request.
REQ-028 A request at addr 0x7FFC SHALL return line 0x1FF word 15 with no wrap-around.
REQ-029 fetch_done and fetch_err SHALL never be high together.

Reset
REQ-030 rst SHALL force the FSM to IDLE and line_valid, fetch_done, fetch_err, mem_cs and mem_addr_valid to 0.
REQ-031 rst SHALL force the tag, wait counter and fetch_insn to 0; the line buffer contents are don't-care.
REQ-032 rst asserted during REQ SHALL drop the bus request in the next cycle and discard any data arriving later.

Structure
REQ-033 FSM state encoding, LINE_BYTES=64 and the address-field widths (tag 9, word 4) SHALL live in a shared package.
REQ-034 A sub-module line_word_sel SHALL select the 32-bit word from the 512-bit line.

Verification
REQ-035 Cold miss: fetch 0x0004, ROM ready after 3 cycles, word1=0x00000013 -> mem_addr=0x0000, fetch_insn=0x00000013, fetch_done one cycle after ready.
REQ-036 Hit: fetch 0x0008 after REQ-035 -> fetch_done next cycle with word2, no mem_cs.
REQ-037 Misaligned: fetch 0x0006 -> fetch_err one cycle later, mem_cs stays 0.
REQ-038 Timeout: ROM never ready, TIMEOUT=8 -> fetch_err after 8 REQ cycles; a following fetch 0x0004 re-issues the bus request.
REQ-039 Flush during fill: flush at REQ cycle 1 -> insn delivered; a repeat fetch 0x0004 misses again.
REQ-040 Top line and reset: fetch 0x7FFC -> mem_addr=0x7FC0, word15 returned; rst mid-REQ -> mem_cs=0 next cycle, no fetch_done.
